// File: rtl/me_pkg.sv
// Shared types and defaults for the motion-estimation sequencer.
package me_pkg;

    localparam int unsigned TB_LENGTH_DEF = 8;
    localparam int unsigned SW_LENGTH_DEF = 32;
    localparam int unsigned SW_HEIGHT_DEF = 32;
    localparam int unsigned PIPE_LAT_DEF  = 3;

    // 14 bits holds 64 * 255 without saturation
    localparam int unsigned SAD_W = 14;

    typedef enum logic [2:0] {
        StIdle,
        StLoadTb,
        StLoadSw,
        StDrain,
        StDone
    } me_state_e;

    // ceil(log2(n)) floored at 1 so tiny sizes still give a legal vector width
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/me_min_tracker.sv
// Aligns candidate positions with the array's SAD output and keeps the running minimum.
module me_min_tracker
    import me_pkg::*;
#(
    parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
    parameter int unsigned MVX_W    = 5,
    parameter int unsigned MVY_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             vld_i,
    input  logic [MVX_W-1:0] cx_i,
    input  logic [MVY_W-1:0] cy_i,
    input  logic [SAD_W-1:0] sad_i,
    input  logic             publish_i,
    output logic [SAD_W-1:0] best_sad_o,
    output logic [MVX_W-1:0] mv_x_o,
    output logic [MVY_W-1:0] mv_y_o
);

    logic             vld_q [PIPE_LAT];
    logic [MVX_W-1:0] cx_q  [PIPE_LAT];
    logic [MVY_W-1:0] cy_q  [PIPE_LAT];

    logic             have_q, have_d;
    logic [SAD_W-1:0] run_sad_q, run_sad_d;
    logic [MVX_W-1:0] run_x_q, run_x_d;
    logic [MVY_W-1:0] run_y_q, run_y_d;
    logic             take;

    logic [SAD_W-1:0] best_sad_q;
    logic [MVX_W-1:0] mv_x_q;
    logic [MVY_W-1:0] mv_y_q;

    // Delay line: candidate tag emerges in the same cycle as its SAD
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                vld_q[i] <= 1'b0;
                cx_q[i]  <= '0;
                cy_q[i]  <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            cx_q[0]  <= cx_i;
            cy_q[0]  <= cy_i;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                cx_q[i]  <= cx_q[i-1];
                cy_q[i]  <= cy_q[i-1];
            end
        end
    end

    // First valid candidate loads unconditionally; later ones need a strictly smaller SAD
    always_comb begin
        take      = vld_q[PIPE_LAT-1] && (!have_q || (sad_i < run_sad_q));
        have_d    = have_q || vld_q[PIPE_LAT-1];
        run_sad_d = take ? sad_i              : run_sad_q;
        run_x_d   = take ? cx_q[PIPE_LAT-1]   : run_x_q;
        run_y_d   = take ? cy_q[PIPE_LAT-1]   : run_y_q;
    end

    // Running minimum, plus published copy that only changes at the end of a search
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_q     <= 1'b0;
            run_sad_q  <= '0;
            run_x_q    <= '0;
            run_y_q    <= '0;
            best_sad_q <= '0;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
        end else begin
            if (clear_i) begin
                have_q <= 1'b0;
            end else begin
                have_q    <= have_d;
                run_sad_q <= run_sad_d;
                run_x_q   <= run_x_d;
                run_y_q   <= run_y_d;
            end
            // next-state values so the last candidate, compared this cycle, is included
            if (publish_i) begin
                best_sad_q <= run_sad_d;
                mv_x_q     <= run_x_d;
                mv_y_q     <= run_y_d;
            end
        end
    end

    assign best_sad_o = best_sad_q;
    assign mv_x_o     = mv_x_q;
    assign mv_y_o     = mv_y_q;

endmodule

// File: rtl/me_ctrl.sv
// Block-search sequencer: loads the template, streams the search window, reports the best match.
module me_ctrl
    import me_pkg::*;
#(
    parameter int unsigned TB_LENGTH = TB_LENGTH_DEF,
    parameter int unsigned SW_LENGTH = SW_LENGTH_DEF,
    parameter int unsigned SW_HEIGHT = SW_HEIGHT_DEF,
    parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF,
    localparam int unsigned TBA_W = clog2_min1(TB_LENGTH * TB_LENGTH),
    localparam int unsigned SWA_W = clog2_min1(SW_LENGTH * SW_HEIGHT),
    localparam int unsigned MVX_W = clog2_min1(SW_LENGTH - TB_LENGTH + 1),
    localparam int unsigned MVY_W = clog2_min1(SW_HEIGHT - TB_LENGTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [TBA_W-1:0] tb_addr,
    output logic [SWA_W-1:0] sw_addr,
    output logic             en_tb,
    output logic             en_sw,
    input  logic [SAD_W-1:0] sad,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [MVX_W-1:0] mv_x,
    output logic [MVY_W-1:0] mv_y
);

    localparam int unsigned TB_PIX = TB_LENGTH * TB_LENGTH;
    localparam int unsigned SW_PIX = SW_LENGTH * SW_HEIGHT;
    localparam int unsigned DRN_W  = clog2_min1(PIPE_LAT + 1);

    localparam logic [TBA_W-1:0] TB_LAST  = TBA_W'(TB_PIX - 1);
    localparam logic [SWA_W-1:0] SW_LAST  = SWA_W'(SW_PIX - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT);
    localparam logic [SWA_W-1:0] EDGE     = SWA_W'(TB_LENGTH - 1);
    localparam logic [SWA_W-1:0] LINE     = SWA_W'(SW_LENGTH);

    me_state_e        state_q;
    logic [TBA_W-1:0] tb_addr_q;
    logic [SWA_W-1:0] sw_addr_q;
    logic [DRN_W-1:0] drain_q;
    logic             busy_q, done_q, pend_q;
    logic             en_tb_q, en_sw_q;
    logic [SWA_W-1:0] k_q;

    logic             launch, publish;
    logic [SWA_W-1:0] k_col, k_row;
    logic             cand_vld;
    logic [MVX_W-1:0] cand_x;
    logic [MVY_W-1:0] cand_y;

    assign launch  = (state_q == StIdle) && (start || pend_q);
    // the last drain cycle carries the final candidate's SAD
    assign publish = (state_q == StDrain) && (drain_q == DRN_LAST);

    // Sequencer FSM with address counters and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tb_addr_q <= '0;
            sw_addr_q <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        state_q <= StLoadTb;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                StLoadTb: begin
                    if (tb_addr_q == TB_LAST) begin
                        tb_addr_q <= '0;
                        state_q   <= StLoadSw;
                    end else begin
                        tb_addr_q <= tb_addr_q + 1'b1;
                    end
                end
                StLoadSw: begin
                    if (sw_addr_q == SW_LAST) begin
                        sw_addr_q <= '0;
                        drain_q   <= '0;
                        state_q   <= StDrain;
                    end else begin
                        sw_addr_q <= sw_addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == DRN_LAST) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    // a start coincident with done is replayed from idle
                    state_q <= StIdle;
                    pend_q  <= start;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory read latency: enables follow their address-issue cycles by one clock
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_tb_q <= 1'b0;
            en_sw_q <= 1'b0;
            k_q     <= '0;
        end else begin
            en_tb_q <= (state_q == StLoadTb);
            en_sw_q <= (state_q == StLoadSw);
            k_q     <= sw_addr_q;
        end
    end

    // Candidate position of the pixel being pushed; valid once a full block fits
    always_comb begin
        k_col    = k_q % LINE;
        k_row    = k_q / LINE;
        cand_vld = en_sw_q && (k_col >= EDGE) && (k_row >= EDGE);
        cand_x   = MVX_W'(k_col - EDGE);
        cand_y   = MVY_W'(k_row - EDGE);
    end

    me_min_tracker #(
        .PIPE_LAT(PIPE_LAT),
        .MVX_W   (MVX_W),
        .MVY_W   (MVY_W)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (launch),
        .vld_i     (cand_vld),
        .cx_i      (cand_x),
        .cy_i      (cand_y),
        .sad_i     (sad),
        .publish_i (publish),
        .best_sad_o(best_sad),
        .mv_x_o    (mv_x),
        .mv_y_o    (mv_y)
    );

    assign tb_addr = tb_addr_q;
    assign sw_addr = sw_addr_q;
    assign en_tb   = en_tb_q;
    assign en_sw   = en_sw_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
